// File: rtl/johnson_phase_dec.sv
// Johnson code phase decoder: registered one-hot/binary phase,
// succession checking, lock FSM and saturating error statistics.
module johnson_phase_dec #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              ctr_in,
  input  logic                          in_vld,
  input  logic                          clr_err,
  output logic [2*WIDTH-1:0]            phase,
  output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
  output logic                          phase_vld,
  output logic                          wrap,
  output logic                          locked,
  output logic                          err,
  output logic                          err_sticky,
  output logic [CNT_W-1:0]              err_cnt
);

  localparam int IW = $clog2(2*WIDTH);
  localparam int GW = $clog2(LOCK_CNT+1);

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] ACQ    = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]         state;
  logic [GW-1:0]      gcnt;
  logic [IW-1:0]      prev_idx;
  logic               prev_vld;

  int                 ones;
  logic               legal;
  logic [IW-1:0]      idx_c;
  logic [IW-1:0]      nxt;
  logic               same;
  logic               good;
  logic               bad;
  logic               err_c;
  logic [2*WIDTH-1:0] onehot;

  // Count ones and check that the code has a single 0/1 boundary.
  always_comb begin
    ones  = 0;
    legal = 1'b1;
    for (int i = 0; i < WIDTH; i++)
      if (ctr_in[i]) ones++;
    for (int i = 0; i < WIDTH-1; i++)
      if (ctr_in[0] ? (!ctr_in[i] && ctr_in[i+1])
                    : (ctr_in[i] && !ctr_in[i+1]))
        legal = 1'b0;
  end

  assign idx_c  = ctr_in[0] ? IW'(2*WIDTH - ones) : IW'(ones);
  assign nxt    = (prev_idx == IW'(2*WIDTH-1)) ? '0 : prev_idx + 1'b1;
  assign same   = prev_vld && (idx_c == prev_idx);
  assign good   = prev_vld && (idx_c == nxt);
  assign bad    = prev_vld && !same && !good;
  assign err_c  = in_vld && (!legal || bad);
  assign onehot = {{(2*WIDTH-1){1'b0}}, 1'b1} << idx_c;
  assign locked = (state == LOCKED);

  // Lock state machine: acquire LOCK_CNT good steps, drop on any error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      gcnt  <= '0;
    end else if (in_vld) begin
      if (err_c) begin
        state <= SEARCH;
        gcnt  <= '0;
      end else begin
        case (state)
          SEARCH: begin
            state <= ACQ;
            gcnt  <= '0;
          end
          ACQ: begin
            if (good) begin
              if (gcnt == GW'(LOCK_CNT-1)) state <= LOCKED;
              else gcnt <= gcnt + 1'b1;
            end
          end
          LOCKED: state <= LOCKED;
          default: begin
            state <= SEARCH;
            gcnt  <= '0;
          end
        endcase
      end
    end
  end

  // Registered phase outputs and previous-index tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      phase_idx <= '0;
      phase_vld <= 1'b0;
      wrap      <= 1'b0;
      err       <= 1'b0;
      prev_idx  <= '0;
      prev_vld  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= err_c;
      if (!in_vld) begin
        phase     <= '0;
        phase_vld <= 1'b0;
      end else if (!legal) begin
        phase     <= '0;
        phase_vld <= 1'b0;
        prev_vld  <= 1'b0;
      end else begin
        phase     <= onehot;
        phase_idx <= idx_c;
        phase_vld <= 1'b1;
        prev_idx  <= idx_c;
        prev_vld  <= 1'b1;
        wrap      <= good && (idx_c == '0);
      end
    end
  end

  // Error statistics; a clear coinciding with an error keeps that error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr_err) begin
      err_sticky <= err_c;
      err_cnt    <= err_c ? CNT_W'(1) : '0;
    end else if (err_c) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_johnson_phase_dec.sv
// Directed bench for johnson_phase_dec, WIDTH=4, LOCK_CNT=4, CNT_W=2.
// Expected values are hand-computed per vector.
module tb_johnson_phase_dec;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ctr_in;
  logic       in_vld;
  logic       clr_err;
  logic [7:0] phase;
  logic [2:0] phase_idx;
  logic       phase_vld;
  logic       wrap;
  logic       locked;
  logic       err;
  logic       err_sticky;
  logic [1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  johnson_phase_dec #(
    .WIDTH(4), .LOCK_CNT(4), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .ctr_in(ctr_in),
    .in_vld(in_vld), .clr_err(clr_err),
    .phase(phase), .phase_idx(phase_idx),
    .phase_vld(phase_vld), .wrap(wrap),
    .locked(locked), .err(err),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic v,
                      input logic clr);
    @(negedge clk);
    ctr_in  = c;
    in_vld  = v;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input int idx,
                      input int ph, input bit vld,
                      input bit wr, input bit lk, input bit er);
    check({tag, ".idx"},  32'(phase_idx), 32'(idx));
    check({tag, ".ph"},   32'(phase), 32'(ph));
    check({tag, ".vld"},  32'(phase_vld), 32'(vld));
    check({tag, ".wrap"}, 32'(wrap), 32'(wr));
    check({tag, ".lock"}, 32'(locked), 32'(lk));
    check({tag, ".err"},  32'(err), 32'(er));
  endtask

  task automatic stats(input string tag, input bit st,
                       input int cnt);
    check({tag, ".sticky"}, 32'(err_sticky), 32'(st));
    check({tag, ".cnt"},    32'(err_cnt), 32'(cnt));
  endtask

  initial begin
    rst = 1'b1; ctr_in = '0; in_vld = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    outs("rst", 0, 8'h00, 0, 0, 0, 0);
    stats("rst", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // acquire lock over 0..4
    step(4'b0000, 1, 0); outs("s0", 0, 8'h01, 1, 0, 0, 0);
    step(4'b1000, 1, 0); outs("s1", 1, 8'h02, 1, 0, 0, 0);
    step(4'b1100, 1, 0); outs("s2", 2, 8'h04, 1, 0, 0, 0);
    step(4'b1110, 1, 0); outs("s3", 3, 8'h08, 1, 0, 0, 0);
    step(4'b1111, 1, 0); outs("s4", 4, 8'h10, 1, 0, 1, 0);
    step(4'b0111, 1, 0); outs("s5", 5, 8'h20, 1, 0, 1, 0);
    step(4'b0011, 1, 0); outs("s6", 6, 8'h40, 1, 0, 1, 0);
    step(4'b0001, 1, 0); outs("s7", 7, 8'h80, 1, 0, 1, 0);
    step(4'b0000, 1, 0); outs("w0", 0, 8'h01, 1, 1, 1, 0);
    step(4'b1000, 1, 0); outs("w1", 1, 8'h02, 1, 0, 1, 0);
    stats("clean", 0, 0);

    // illegal code while locked
    step(4'b1010, 1, 0); outs("ill", 1, 8'h00, 0, 0, 0, 1);
    stats("ill", 1, 1);
    step(4'b1100, 1, 0); outs("r2", 2, 8'h04, 1, 0, 0, 0);
    step(4'b1110, 1, 0); outs("r3", 3, 8'h08, 1, 0, 0, 0);
    step(4'b1111, 1, 0); outs("r4", 4, 8'h10, 1, 0, 0, 0);
    step(4'b0111, 1, 0); outs("r5", 5, 8'h20, 1, 0, 0, 0);
    step(4'b0011, 1, 0); outs("r6", 6, 8'h40, 1, 0, 1, 0);

    // bad steps: 6->1 then 1->3, then a hold
    step(4'b1000, 1, 0); outs("b1", 1, 8'h02, 1, 0, 0, 1);
    stats("b1", 1, 2);
    step(4'b1110, 1, 0); outs("b3", 3, 8'h08, 1, 0, 0, 1);
    stats("b3", 1, 3);
    step(4'b1110, 1, 0); outs("hold", 3, 8'h08, 1, 0, 0, 0);
    stats("hold", 1, 3);

    // saturation and clear
    step(4'b0101, 1, 0); outs("sat", 3, 8'h00, 0, 0, 0, 1);
    stats("sat", 1, 3);
    step(4'b1001, 1, 1); outs("clre", 3, 8'h00, 0, 0, 0, 1);
    stats("clre", 1, 1);
    step(4'b1110, 1, 1); outs("clr", 3, 8'h08, 1, 0, 0, 0);
    stats("clr", 0, 0);

    // in_vld low holds index and state
    step(4'b0000, 0, 0); outs("nv", 3, 8'h00, 0, 0, 0, 0);

    // relock, wrap, then async reset
    step(4'b1111, 1, 0); outs("l4", 4, 8'h10, 1, 0, 0, 0);
    step(4'b0111, 1, 0); outs("l5", 5, 8'h20, 1, 0, 0, 0);
    step(4'b0011, 1, 0); outs("l6", 6, 8'h40, 1, 0, 0, 0);
    step(4'b0001, 1, 0); outs("l7", 7, 8'h80, 1, 0, 1, 0);
    step(4'b0000, 1, 0); outs("l0", 0, 8'h01, 1, 1, 1, 0);
    step(4'b1000, 1, 0); outs("l1", 1, 8'h02, 1, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    outs("arst", 0, 8'h00, 0, 0, 0, 0);
    stats("arst", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b1100, 1, 0); outs("post", 2, 8'h04, 1, 0, 0, 0);
    stats("post", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
